switch_input_responder: RTL and testbench
=========================================

Name: switch_input_responder

Overview:
- Responder side of the processor's user-input handshake: answers the processor's input request with a debounced, latched switch value.
- Arms when the processor raises input_flag and the PC is stalled on an input instruction.
- Waits for a fresh, debounced press of the insert key, then captures SW, drives user_input and pulses input_done so the PC advances exactly once.
- Sits between the board switches/key and the PC / register-file write-back mux.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable Clock cycles required before a key level change is accepted (min 1).
- CNT_W, 16, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- INSERT_ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed (board pushbutton); 0 = active-high.

Ports:
- Clock  in  1  processor clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- input_flag  in  1  processor requests input; held high while the input instruction is stalled.
- insert  in  1  raw, asynchronous, bouncing key.
- SW  in  16  raw switch value.
- user_input  out  32  captured value fed to write-back.
- input_done  out  1  one-cycle pulse: value valid, release the PC.
- waiting  out  1  high while armed and waiting for a press (LED).

Behaviour:
- Synchronisers:
  - insert goes through a 2-flop synchroniser, then polarity-normalised to key_raw (1 = pressed).
  - SW goes through a 2-flop synchroniser.
- Debouncer:
  - key_stable has reset value 0.
  - The counter counts while key_raw != key_stable and clears when they match.
  - When the count reaches DEBOUNCE_CYCLES-1, key_stable takes key_raw and the counter clears.
  - press_evt = one-cycle pulse on the 0->1 transition of key_stable.
- FSM states: IDLE, ARMED, CAPTURE, DONE, RELEASE.
  - IDLE: if input_flag=1 and key_stable=0 -> ARMED. If input_flag=1 and key_stable=1 -> RELEASE (a key already held never counts as a press).
  - ARMED: waiting=1. press_evt -> CAPTURE. input_flag=0 -> IDLE, no capture.
  - CAPTURE: user_input <= extended synchronised SW (see Optional Feature) -> DONE.
  - DONE: input_done=1 for exactly this cycle -> RELEASE.
  - RELEASE: stay until key_stable=0 and input_flag=0, then -> IDLE. This guarantees one capture per press and per request.
- Latency: press_evt to input_done is 2 cycles (CAPTURE, then DONE). Raw key edge to press_evt is 2 sync cycles + DEBOUNCE_CYCLES.
- user_input holds its last captured value indefinitely; it changes only in CAPTURE.
- Simultaneous events:
  - input_flag falling on the same cycle as press_evt in ARMED: the drop wins -> IDLE, no capture.
  - input_flag falling during CAPTURE/DONE does not abort; the pulse still issues.
- Reset (asserted at any time, including mid-handshake):
  - All state cleared immediately: FSM=IDLE, user_input=0, input_done=0, waiting=0, key_stable=0, counter=0, synchronisers=0.
  - After release, a key still held is seen as stable-pressed only after debounce and cannot trigger a capture until it has been released.

Optional Feature:
- SW_SIGN_EXTEND_EN defined: user_input = {16{SW_sync[15]}, SW_sync}, so negative immediates can be entered.
- Not defined: user_input = {16'b0, SW_sync} (zero-extended).
- No other behaviour differs.

Test Plan:
- Basic capture: reset, DEBOUNCE_CYCLES=4, SW=16'h00A5, input_flag=1, key pressed clean for 10 cycles -> exactly one input_done pulse; user_input=32'h000000A5; waiting drops in CAPTURE.
- Bounce: key toggles every 2 cycles for 12 cycles, then held -> no input_done during bouncing; exactly one pulse 2+4+2 cycles after the key settles.
- Held-key rejection: key held before input_flag rises -> FSM goes to RELEASE, no pulse. After release, flag drop and a new request with a fresh press -> one pulse.
- Abort: input_flag drops while ARMED, then a press follows -> no pulse; user_input keeps its prior value 32'h000000A5.
- Sign extension: SW=16'hFFFE -> user_input=32'hFFFFFFFE with SW_SIGN_EXTEND_EN defined, 32'h0000FFFE without.
- Mid-op reset: assert reset (0) in the DONE cycle -> input_done=0, user_input=0 in that same cycle; no pulse after reset is released while the key is still held.

Source files
------------

// File: rtl/switch_input_responder.sv
// Responder half of the processor's user-input handshake: debounced insert key, latched SW value.
// Optional SW_SIGN_EXTEND_EN: sign-extend the 16-bit switch value instead of zero-extending it.
module switch_input_responder #(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int CNT_W             = 16,
  parameter bit INSERT_ACTIVE_LOW = 1'b1
) (
  input  logic        Clock,
  input  logic        reset,
  input  logic        input_flag,
  input  logic        insert,
  input  logic [15:0] SW,
  output logic [31:0] user_input,
  output logic        input_done,
  output logic        waiting
);

  localparam int SYNC_STAGES = 2;
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, DONE, RELEASE} state_t;

  state_t                         state, state_nxt;
  logic [SYNC_STAGES-1:0]         ins_sync;
  logic [SYNC_STAGES-1:0][15:0]   sw_sync;
  logic [SYNC_STAGES-1:0]         vld_pipe;
  logic                           sync_ok;
  logic                           key_raw;
  logic                           key_stable;
  logic                           key_prev;
  logic                           rel_seen;
  logic [CNT_W-1:0]               db_cnt;
  logic                           press_evt;
  logic                           capture_en;
  logic [31:0]                    sw_ext;

  // vld_pipe marks when the synchronisers hold real samples rather than reset zeros.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      ins_sync <= '0;
      sw_sync  <= '0;
      vld_pipe <= '0;
    end else begin
      ins_sync <= {ins_sync[SYNC_STAGES-2:0], insert};
      sw_sync  <= {sw_sync[SYNC_STAGES-2:0], SW};
      vld_pipe <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_ok = vld_pipe[SYNC_STAGES-1];
  assign key_raw = INSERT_ACTIVE_LOW ? ~ins_sync[SYNC_STAGES-1] : ins_sync[SYNC_STAGES-1];

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      key_stable <= 1'b0;
      key_prev   <= 1'b0;
      rel_seen   <= 1'b0;
      db_cnt     <= '0;
    end else begin
      key_prev <= key_stable;
      if (sync_ok && !key_raw)
        rel_seen <= 1'b1;
      if (key_raw == key_stable)
        db_cnt <= '0;
      else if (db_cnt == DB_MAX) begin
        key_stable <= key_raw;
        db_cnt     <= '0;
      end else
        db_cnt <= db_cnt + 1'b1;
    end
  end

  // A key held through reset must be seen released before any rising edge counts as a press.
  assign press_evt = key_stable & ~key_prev & rel_seen;

`ifdef SW_SIGN_EXTEND_EN
  assign sw_ext = {{16{sw_sync[SYNC_STAGES-1][15]}}, sw_sync[SYNC_STAGES-1]};
`else
  assign sw_ext = {16'b0, sw_sync[SYNC_STAGES-1]};
`endif

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (input_flag) state_nxt = key_stable ? RELEASE : ARMED;
      ARMED:   if (!input_flag)    state_nxt = IDLE;
               else if (press_evt) state_nxt = CAPTURE;
      CAPTURE: state_nxt = DONE;
      DONE:    state_nxt = RELEASE;
      RELEASE: if (!key_stable && !input_flag) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    waiting    = (state == ARMED);
    input_done = (state == DONE);
    capture_en = (state == CAPTURE);
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset)          user_input <= '0;
    else if (capture_en) user_input <= sw_ext;
  end

endmodule

// File: tb/tb_switch_input_responder.sv
// Scoreboard bench for switch_input_responder: stimulus pushes expected captures, a monitor pops on input_done.
module tb_switch_input_responder;

  logic        Clock = 1'b0;
  logic        reset;
  logic        input_flag;
  logic        insert;
  logic [15:0] SW;
  logic [31:0] user_input;
  logic        input_done;
  logic        waiting;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  switch_input_responder #(
    .DEBOUNCE_CYCLES  (4),
    .CNT_W            (16),
    .INSERT_ACTIVE_LOW(1'b1)
  ) dut (
    .Clock     (Clock),
    .reset     (reset),
    .input_flag(input_flag),
    .insert    (insert),
    .SW        (SW),
    .user_input(user_input),
    .input_done(input_done),
    .waiting   (waiting)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  // Press the (active-low) key cleanly, expect one capture 8 cycles after the raw edge.
  task automatic press_and_expect(input logic [31:0] val);
    exp_t e;
    @(posedge Clock); #1;
    insert = 1'b0;
    e.val = val;
    e.cyc = cyc + 8;
    sb.push_back(e);
    wait_cyc(12);
    insert = 1'b1;
  endtask

  task automatic end_request();
    input_flag = 1'b0;
    wait_cyc(10);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge Clock);
      if (input_done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: input_done=1 with user_input %h, none expected (cycle %0d)",
                   user_input, cyc);
        end else begin
          e = sb.pop_front();
          chk("capture_value", user_input, e.val);
          chk("pulse_cycle", cyc, e.cyc);
        end
      end
    end
  endtask

  initial begin
    logic [31:0] sx_exp;
    fork
      monitor();
    join_none

    reset = 1'b0; input_flag = 1'b0; insert = 1'b1; SW = 16'h0000;
    repeat (3) @(negedge Clock);
    chk("reset_user_input", user_input, 32'h0);
    chk("reset_input_done", {31'b0, input_done}, 32'h0);
    chk("reset_waiting", {31'b0, waiting}, 32'h0);
    @(posedge Clock); #1;
    reset = 1'b1;
    wait_cyc(6);

    // Basic capture, with waiting observed dropping as CAPTURE is entered.
    begin
      exp_t e;
      int   n;
      SW = 16'h00A5; input_flag = 1'b1;
      wait_cyc(3);
      chk("armed_waiting", {31'b0, waiting}, 32'h1);
      @(posedge Clock); #1;
      insert = 1'b0;
      n = cyc;
      e.val = 32'h000000A5; e.cyc = n + 8;
      sb.push_back(e);
      repeat (6) @(posedge Clock);
      @(negedge Clock);
      chk("waiting_before_capture", {31'b0, waiting}, 32'h1);
      @(posedge Clock);
      @(negedge Clock);
      chk("waiting_in_capture", {31'b0, waiting}, 32'h0);
      wait_cyc(4);
      insert = 1'b1;
      end_request();
    end

    // Abort: flag drops while armed, later press must not capture.
    input_flag = 1'b1;
    wait_cyc(3);
    chk("abort_armed", {31'b0, waiting}, 32'h1);
    input_flag = 1'b0;
    wait_cyc(2);
    chk("abort_idle", {31'b0, waiting}, 32'h0);
    insert = 1'b0;
    wait_cyc(12);
    insert = 1'b1;
    wait_cyc(10);
    chk("abort_keeps_value", user_input, 32'h000000A5);

    // Bounce: toggle every 2 cycles, then settle pressed.
    SW = 16'h1234; input_flag = 1'b1;
    wait_cyc(3);
    for (int i = 0; i < 6; i++) begin
      insert = i[0];
      wait_cyc(2);
    end
    press_and_expect(32'h00001234);
    end_request();

    // Held key before request goes straight to RELEASE.
    insert = 1'b0;
    wait_cyc(10);
    input_flag = 1'b1;
    wait_cyc(10);
    chk("held_no_arm", {31'b0, waiting}, 32'h0);
    insert = 1'b1;
    wait_cyc(10);
    chk("held_release_waits_flag", {31'b0, waiting}, 32'h0);
    input_flag = 1'b0;
    wait_cyc(3);
    SW = 16'h0042; input_flag = 1'b1;
    wait_cyc(3);
    chk("held_rearm", {31'b0, waiting}, 32'h1);
    press_and_expect(32'h00000042);
    end_request();

    // Sign / zero extension of a negative switch value.
`ifdef SW_SIGN_EXTEND_EN
    sx_exp = 32'hFFFFFFFE;
`else
    sx_exp = 32'h0000FFFE;
`endif
    SW = 16'hFFFE; input_flag = 1'b1;
    wait_cyc(3);
    press_and_expect(sx_exp);
    end_request();
    chk("extend_hold", user_input, sx_exp);

    // Reset in the DONE cycle, key still held afterwards.
    SW = 16'h5555; input_flag = 1'b1;
    wait_cyc(3);
    @(posedge Clock); #1;
    insert = 1'b0;
    repeat (8) @(posedge Clock);
    #1;
    chk("done_before_reset", {31'b0, input_done}, 32'h1);
    reset = 1'b0;
    @(negedge Clock);
    chk("midreset_input_done", {31'b0, input_done}, 32'h0);
    chk("midreset_user_input", user_input, 32'h0);
    chk("midreset_waiting", {31'b0, waiting}, 32'h0);
    wait_cyc(2);
    reset = 1'b1;
    wait_cyc(20);
    chk("held_after_reset_armed", {31'b0, waiting}, 32'h1);
    chk("held_after_reset_value", user_input, 32'h0);
    insert = 1'b1;
    wait_cyc(10);
    SW = 16'h0077;
    wait_cyc(3);
    press_and_expect(32'h00000077);
    end_request();

    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
